screen_writer: RTL and testbench

Upstream feeder of the 80x25 text display's character buffer. Consumes a byte stream (from the UART receiver) with a valid/ready handshake, interprets printable characters, control characters and a VT52 escape subset, and drives a single write port into the 2000-byte screen memory. Scrolling is done by moving a top-line offset that the display stage adds to its row counter, plus clearing the newly exposed line.

---
 rtl/screen_writer_if.sv | 23 ++
 rtl/screen_writer.sv | 226 ++++++++++++++++++++++
 tb/tb_screen_writer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/screen_writer_if.sv
// Byte-stream input and screen-memory write port of screen_writer, with cursor/scroll status.
// The DUT uses the slave modport. The upstream byte source and display use master.
interface screen_writer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [4:0]  top_line;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_addr, wr_data, wr_en, cursor_col, cursor_row, top_line
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_addr, wr_data, wr_en, cursor_col, cursor_row, top_line
  );
endinterface

// File: rtl/screen_writer.sv
// screen_writer: turns a received byte stream into writes to the 80x25 screen memory, scrolling via top_line.
// Define VT52_ESC_EN to enable the VT52 escape subset (ESC A/B/C/D/H/J/K/Y).
module screen_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 25
) (
  input logic            clk,
  input logic            clr_n,
  screen_writer_if.slave bus
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [7:0] SPACE    = 8'h20;

`ifdef VT52_ESC_EN
  typedef enum logic [2:0] {CLR_ALL, IDLE, ESC, ESC_Y_ROW, ESC_Y_COL, CLEAR} state_t;
`else
  typedef enum logic [2:0] {CLR_ALL, IDLE, CLEAR} state_t;
`endif

  state_t      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [4:0]  top_q, top_d;
  logic [6:0]  clr_col_q, clr_col_d;
  logic [4:0]  clr_row_q, clr_row_d;
  logic [4:0]  clr_end_q, clr_end_d;
  logic        wr_en_q, wr_en_d;
  logic [10:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        in_ready_q, in_ready_d;
`ifdef VT52_ESC_EN
  logic [7:0]  esc_row_q, esc_row_d;
  logic [7:0]  y_val;
`endif

  logic        accept;
  logic        is_print;
  logic [7:0]  tab_sum;
  logic [6:0]  tab_col;
  logic [10:0] cursor_addr;
  logic [10:0] clr_addr;

  // Logical (row,col) to physical address: rotate row by top_line, then row*64 + row*16 + col.
  function automatic logic [10:0] phys_addr(input logic [4:0] row, input logic [6:0] col,
                                            input logic [4:0] top);
    logic [5:0] sum;
    logic [4:0] prow;
    sum  = {1'b0, row} + {1'b0, top};
    prow = (sum >= 6'(ROWS)) ? 5'(sum - 6'(ROWS)) : sum[4:0];
    return {prow, 6'b0} + {2'b0, prow, 4'b0} + {4'b0, col};
  endfunction

  assign accept      = bus.in_valid && in_ready_q;
  assign is_print    = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);
  assign tab_sum     = {1'b0, col_q | 7'd7} + 8'd1;
  assign tab_col     = (tab_sum > {1'b0, LAST_COL}) ? LAST_COL : tab_sum[6:0];
  assign cursor_addr = phys_addr(row_q, col_q, top_q);
  assign clr_addr    = phys_addr(clr_row_q, clr_col_q, top_q);
`ifdef VT52_ESC_EN
  assign y_val       = bus.in_data - SPACE;
`endif

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    top_d      = top_q;
    clr_col_d  = clr_col_q;
    clr_row_d  = clr_row_q;
    clr_end_d  = clr_end_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    in_ready_d = in_ready_q;
`ifdef VT52_ESC_EN
    esc_row_d  = esc_row_q;
`endif

    case (state_q)
      // Power-up fill and partial clears share one walker that ends at col 79 of clr_end.
      CLR_ALL, CLEAR: begin
        wr_en_d    = 1'b1;
        wr_addr_d  = clr_addr;
        wr_data_d  = SPACE;
        in_ready_d = 1'b0;
        if (clr_col_q == LAST_COL) begin
          clr_col_d = 7'd0;
          if (clr_row_q == clr_end_q) begin
            state_d = IDLE;
          end else begin
            clr_row_d = clr_row_q + 5'd1;
          end
        end else begin
          clr_col_d = clr_col_q + 7'd1;
        end
      end

      IDLE: begin
        in_ready_d = 1'b1;
        if (accept) begin
          if (is_print) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cursor_addr;
            wr_data_d = bus.in_data;
            if (col_q != LAST_COL) col_d = col_q + 7'd1;
          end else begin
            case (bus.in_data)
              8'h0D: col_d = 7'd0;
              8'h08: if (col_q != 7'd0) col_d = col_q - 7'd1;
              8'h09: col_d = tab_col;
              8'h0A: begin
                if (row_q != LAST_ROW) begin
                  row_d = row_q + 5'd1;
                end else begin
                  top_d      = (top_q == LAST_ROW) ? 5'd0 : top_q + 5'd1;
                  clr_row_d  = LAST_ROW;
                  clr_col_d  = 7'd0;
                  clr_end_d  = LAST_ROW;
                  in_ready_d = 1'b0;
                  state_d    = CLEAR;
                end
              end
`ifdef VT52_ESC_EN
              8'h1B: state_d = ESC;
`endif
              default: ;
            endcase
          end
        end
      end

`ifdef VT52_ESC_EN
      ESC: begin
        in_ready_d = 1'b1;
        if (accept) begin
          state_d = IDLE;
          case (bus.in_data)
            8'h41: if (row_q != 5'd0) row_d = row_q - 5'd1;
            8'h42: if (row_q != LAST_ROW) row_d = row_q + 5'd1;
            8'h43: if (col_q != LAST_COL) col_d = col_q + 7'd1;
            8'h44: if (col_q != 7'd0) col_d = col_q - 7'd1;
            8'h48: begin
              row_d = 5'd0;
              col_d = 7'd0;
            end
            8'h4A, 8'h4B: begin
              clr_row_d  = row_q;
              clr_col_d  = col_q;
              clr_end_d  = (bus.in_data == 8'h4A) ? LAST_ROW : row_q;
              in_ready_d = 1'b0;
              state_d    = CLEAR;
            end
            8'h59: state_d = ESC_Y_ROW;
            default: ;
          endcase
        end
      end

      ESC_Y_ROW: begin
        in_ready_d = 1'b1;
        if (accept) begin
          esc_row_d = y_val;
          state_d   = ESC_Y_COL;
        end
      end

      // Out-of-range coordinates (including bytes below 0x20, which wrap high) leave that axis alone.
      ESC_Y_COL: begin
        in_ready_d = 1'b1;
        if (accept) begin
          if (esc_row_q <= {3'b0, LAST_ROW}) row_d = esc_row_q[4:0];
          if (y_val <= {1'b0, LAST_COL}) col_d = y_val[6:0];
          state_d = IDLE;
        end
      end
`endif

      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= CLR_ALL;
      col_q      <= 7'd0;
      row_q      <= 5'd0;
      top_q      <= 5'd0;
      clr_col_q  <= 7'd0;
      clr_row_q  <= 5'd0;
      clr_end_q  <= LAST_ROW;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 11'd0;
      wr_data_q  <= SPACE;
      in_ready_q <= 1'b0;
`ifdef VT52_ESC_EN
      esc_row_q  <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      top_q      <= top_d;
      clr_col_q  <= clr_col_d;
      clr_row_q  <= clr_row_d;
      clr_end_q  <= clr_end_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      in_ready_q <= in_ready_d;
`ifdef VT52_ESC_EN
      esc_row_q  <= esc_row_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.cursor_col = col_q;
  assign bus.cursor_row = row_q;
  assign bus.top_line   = top_q;

endmodule

// File: tb/tb_screen_writer.sv
// Directed self-checking bench for screen_writer: table of single-byte vectors plus
// hand-written sequences for power-up fill, scrolling, clears and reset mid-operation.
module tb_screen_writer;
  logic clk = 1'b0;
  logic clr_n = 1'b0;

  screen_writer_if bus();

  screen_writer dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_t;
  wr_t wrLog[$];

  // Every memory write is logged on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) wrLog.push_back(wr_t'({bus.wr_addr, bus.wr_data}));
  end

  typedef struct {
    logic [7:0]  din;
    logic        we;
    logic [10:0] addr;
    logic [7:0]  data;
    logic [4:0]  row;
    logic [6:0]  col;
  } vec_t;
  vec_t vecs[16];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Time is always at posedge+1 when a task starts and when it returns.
  task automatic waitReady(input int limit, input string name);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.in_ready !== 1'b1) checkOutput("in_ready timeout", 32'(bus.in_ready), 32'd1);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic checkCursor(input string name, input int row, input int col);
    checkOutput({name, " row"}, 32'(bus.cursor_row), 32'(row));
    checkOutput({name, " col"}, 32'(bus.cursor_col), 32'(col));
  endtask

  // Checks that the log holds exactly 'count' spaces at consecutive addresses from 'base'.
  task automatic checkClearLog(input string name, input int base, input int count);
    int bad = 0;
    checkOutput({name, " write count"}, 32'(wrLog.size()), 32'(count));
    foreach (wrLog[i]) begin
      if (wrLog[i].addr != 11'(base + i) || wrLog[i].data != 8'h20) bad++;
    end
    checkOutput({name, " bad writes"}, 32'(bad), 32'd0);
  endtask

  // Asserts reset, checks reset values, releases and checks the full power-up fill.
  task automatic doReset();
    logic lastWe = 1'b0;
    int   cyc = 0;
    clr_n = 1'b0;
    #1;
    checkOutput("rst wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("rst in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst wr_addr", 32'(bus.wr_addr), 32'd0);
    checkOutput("rst wr_data", 32'(bus.wr_data), 32'h20);
    checkOutput("rst top_line", 32'(bus.top_line), 32'd0);
    checkCursor("rst", 0, 0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    wrLog.delete();
    do begin
      @(posedge clk); #1;
      cyc++;
      if (bus.in_ready !== 1'b1) lastWe = bus.wr_en;
    end while (bus.in_ready !== 1'b1 && cyc < 2100);
    checkOutput("clr_all ready", 32'(bus.in_ready), 32'd1);
    checkOutput("clr_all cycles", 32'(cyc), 32'd2001);
    checkOutput("clr_all last write before ready", 32'(lastWe), 32'd1);
    checkOutput("clr_all wr_en at ready", 32'(bus.wr_en), 32'd0);
    checkClearLog("clr_all", 0, 2000);
    checkCursor("after clr_all", 0, 0);
    checkOutput("after clr_all top_line", 32'(bus.top_line), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expCol;
    int bad;

    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    //            din    we    addr    data   row col
    vecs[0]  = '{8'h41, 1'b1, 11'd0,  8'h41, 5'd0, 7'd1};
    vecs[1]  = '{8'h42, 1'b1, 11'd1,  8'h42, 5'd0, 7'd2};
    vecs[2]  = '{8'h0D, 1'b0, 11'd0,  8'h00, 5'd0, 7'd0};
    vecs[3]  = '{8'h0A, 1'b0, 11'd0,  8'h00, 5'd1, 7'd0};
    vecs[4]  = '{8'h43, 1'b1, 11'd80, 8'h43, 5'd1, 7'd1};
    vecs[5]  = '{8'h09, 1'b0, 11'd0,  8'h00, 5'd1, 7'd8};
    vecs[6]  = '{8'h08, 1'b0, 11'd0,  8'h00, 5'd1, 7'd7};
    vecs[7]  = '{8'h7F, 1'b0, 11'd0,  8'h00, 5'd1, 7'd7};
    vecs[8]  = '{8'h00, 1'b0, 11'd0,  8'h00, 5'd1, 7'd7};
    vecs[9]  = '{8'h7A, 1'b1, 11'd87, 8'h7A, 5'd1, 7'd8};
    vecs[10] = '{8'h09, 1'b0, 11'd0,  8'h00, 5'd1, 7'd16};
    vecs[11] = '{8'h0D, 1'b0, 11'd0,  8'h00, 5'd1, 7'd0};
    vecs[12] = '{8'h08, 1'b0, 11'd0,  8'h00, 5'd1, 7'd0};
    vecs[13] = '{8'h20, 1'b1, 11'd80, 8'h20, 5'd1, 7'd1};
    vecs[14] = '{8'h7E, 1'b1, 11'd81, 8'h7E, 5'd1, 7'd2};
    vecs[15] = '{8'hFF, 1'b0, 11'd0,  8'h00, 5'd1, 7'd2};

    @(posedge clk); #1;
    doReset();

    $display("[TB] single-byte vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].din);
      checkOutput($sformatf("vec%0d wr_en", i), 32'(bus.wr_en), 32'(vecs[i].we));
      if (vecs[i].we) begin
        checkOutput($sformatf("vec%0d wr_addr", i), 32'(bus.wr_addr), 32'(vecs[i].addr));
        checkOutput($sformatf("vec%0d wr_data", i), 32'(bus.wr_data), 32'(vecs[i].data));
      end
      checkCursor($sformatf("vec%0d", i), int'(vecs[i].row), int'(vecs[i].col));
    end

    $display("[TB] tab stops up to column 79, then overwrite at column 79");
    applyStimulus(8'h0D);
    expCol = 0;
    for (int i = 0; i < 10; i++) begin
      expCol = ((expCol | 7) + 1 > 79) ? 79 : (expCol | 7) + 1;
      applyStimulus(8'h09);
      checkOutput($sformatf("tab%0d col", i), 32'(bus.cursor_col), 32'(expCol));
    end
    checkOutput("tab final col", 32'(bus.cursor_col), 32'd79);
    applyStimulus(8'h78);
    checkOutput("col79 write addr", 32'(bus.wr_addr), 32'd159);
    checkOutput("col79 col sat", 32'(bus.cursor_col), 32'd79);
    applyStimulus(8'h79);
    checkOutput("col79 overwrite en", 32'(bus.wr_en), 32'd1);
    checkOutput("col79 overwrite addr", 32'(bus.wr_addr), 32'd159);
    checkOutput("col79 overwrite data", 32'(bus.wr_data), 32'h79);

    $display("[TB] line feeds and scrolling");
    doReset();
    wrLog.delete();
    for (int i = 0; i < 24; i++) applyStimulus(8'h0A);
    checkCursor("24 LF", 24, 0);
    checkOutput("24 LF top_line", 32'(bus.top_line), 32'd0);
    checkOutput("24 LF no writes", 32'(wrLog.size()), 32'd0);
    applyStimulus(8'h0A);
    checkOutput("scroll1 top_line", 32'(bus.top_line), 32'd1);
    checkOutput("scroll1 in_ready", 32'(bus.in_ready), 32'd0);
    checkCursor("scroll1", 24, 0);
    waitReady(200, "scroll1 ready");
    checkClearLog("scroll1", 0, 80);
    applyStimulus(8'h4D);
    checkOutput("after scroll1 addr", 32'(bus.wr_addr), 32'd0);
    checkOutput("after scroll1 data", 32'(bus.wr_data), 32'h4D);
    for (int i = 0; i < 23; i++) applyStimulus(8'h0A);
    waitReady(200, "scroll24 ready");
    checkOutput("scroll24 top_line", 32'(bus.top_line), 32'd24);
    wrLog.delete();
    applyStimulus(8'h0A);
    checkOutput("scroll wrap top_line", 32'(bus.top_line), 32'd0);
    waitReady(200, "scroll wrap ready");
    checkClearLog("scroll wrap", 1920, 80);
    checkCursor("scroll wrap", 24, 1);
    applyStimulus(8'h4E);
    checkOutput("after wrap addr", 32'(bus.wr_addr), 32'd1921);

    $display("[TB] reset in the middle of a scroll clear");
    applyStimulus(8'h0A);
    repeat (10) begin
      @(posedge clk); #1;
    end
    checkOutput("mid clear wr_en before reset", 32'(bus.wr_en), 32'd1);
    doReset();

`ifdef VT52_ESC_EN
    $display("[TB] VT52 escape sequences");
    applyStimulus(8'h1B); applyStimulus(8'h59); applyStimulus(8'h25); applyStimulus(8'h2A);
    checkCursor("ESC Y 5,10", 5, 10);
    applyStimulus(8'h78);
    checkOutput("ESC Y write en", 32'(bus.wr_en), 32'd1);
    checkOutput("ESC Y write addr", 32'(bus.wr_addr), 32'd410);
    checkOutput("ESC Y write data", 32'(bus.wr_data), 32'h78);
    applyStimulus(8'h1B); applyStimulus(8'h59); applyStimulus(8'h60); applyStimulus(8'h21);
    checkCursor("ESC Y bad row", 5, 1);
    applyStimulus(8'h1B); applyStimulus(8'h59); applyStimulus(8'h23); applyStimulus(8'h6E);
    checkCursor("ESC Y 3,78", 3, 78);
    wrLog.delete();
    applyStimulus(8'h1B); applyStimulus(8'h4B);
    checkOutput("ESC K in_ready", 32'(bus.in_ready), 32'd0);
    waitReady(200, "ESC K ready");
    checkOutput("ESC K count", 32'(wrLog.size()), 32'd2);
    bad = 0;
    foreach (wrLog[i]) if (wrLog[i].addr != 11'(318 + i) || wrLog[i].data != 8'h20) bad++;
    checkOutput("ESC K bad writes", 32'(bad), 32'd0);
    checkCursor("ESC K cursor", 3, 78);
    applyStimulus(8'h1B); applyStimulus(8'h51);
    checkOutput("ESC Q no write", 32'(bus.wr_en), 32'd0);
    applyStimulus(8'h61);
    checkOutput("after ESC Q addr", 32'(bus.wr_addr), 32'd318);
    checkOutput("after ESC Q en", 32'(bus.wr_en), 32'd1);
    applyStimulus(8'h1B); applyStimulus(8'h43);
    checkCursor("ESC C sat", 3, 79);
    applyStimulus(8'h1B); applyStimulus(8'h48);
    checkCursor("ESC H", 0, 0);
    applyStimulus(8'h1B); applyStimulus(8'h41);
    applyStimulus(8'h1B); applyStimulus(8'h44);
    checkCursor("ESC A/D sat", 0, 0);
    applyStimulus(8'h1B); applyStimulus(8'h42);
    checkCursor("ESC B", 1, 0);
    applyStimulus(8'h1B); applyStimulus(8'h59); applyStimulus(8'h38); applyStimulus(8'h6E);
    wrLog.delete();
    applyStimulus(8'h1B); applyStimulus(8'h4A);
    waitReady(200, "ESC J tail ready");
    checkClearLog("ESC J tail", 1998, 2);
    checkCursor("ESC J tail cursor", 24, 78);
    applyStimulus(8'h1B); applyStimulus(8'h48);
    applyStimulus(8'h1B); applyStimulus(8'h4A);
    repeat (50) begin
      @(posedge clk); #1;
    end
    checkOutput("ESC J mid wr_en", 32'(bus.wr_en), 32'd1);
    doReset();
`else
    $display("[TB] ESC ignored without escape support");
    applyStimulus(8'h1B);
    checkOutput("ESC ignored en", 32'(bus.wr_en), 32'd0);
    checkCursor("ESC ignored", 0, 0);
    applyStimulus(8'h59);
    checkOutput("Y printable en", 32'(bus.wr_en), 32'd1);
    checkOutput("Y printable addr", 32'(bus.wr_addr), 32'd0);
    checkOutput("Y printable data", 32'(bus.wr_data), 32'h59);
    checkCursor("Y printable", 0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
